stopwatch_control: RTL and testbench
====================================

Name: stopwatch_control

Overview:
Control and timebase stage placed directly upstream of the stopwatch seconds counter. It synchronises the start/stop/reset push-buttons, runs an IDLE/RUNNING/PAUSED state machine, and divides clk into a one-cycle tick_en pulse per second. It also issues a one-cycle clr pulse. tick_en drives the counter's enable input and clr drives its reset input.

Parameters:
TICK_DIV, 100000000, clk cycles per tick_en pulse (≥2); prescaler width = $clog2(TICK_DIV)
DEBOUNCE_CYCLES, 1000000, stable-sample count required by the debounce filter (≥2); used only when STOPWATCH_DEBOUNCE_EN is defined

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
btn_start  input  1  start button, asynchronous level, active-high
btn_stop  input  1  stop/pause button, asynchronous level, active-high
btn_reset  input  1  clear button, asynchronous level, active-high
tick_en  output  1  one-cycle pulse every TICK_DIV cycles while RUNNING
clr  output  1  one-cycle pulse that clears the downstream counters
running  output  1  high while state == RUNNING
paused  output  1  high while state == PAUSED
state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED; 11 never reached (recovers to IDLE)

Behaviour:
- rst_n low: state=IDLE. tick_en=0, clr=0, running=0, paused=0. Prescaler, synchronisers and edge registers are 0.
- Each button passes through a 2-flop synchroniser, then a rising-edge detector (sync & ~sync_d). A level held high produces exactly one command.
- Latency: a button rising before clk edge k changes state/outputs at edge k+2 (no debounce).
- Command priority within one cycle: reset > stop > start.
- Transitions:
  - IDLE: start→RUNNING. reset→IDLE with clr. stop ignored.
  - RUNNING: stop→PAUSED. reset→IDLE with clr. start ignored.
  - PAUSED: start→RUNNING. reset→IDLE with clr. stop ignored.
  - Illegal 11: →IDLE.
- clr is registered and high for exactly one cycle, in the same cycle the state register shows the post-reset state. It is never asserted by rst_n.
- Prescaler behaviour:
  - Counts only while state==RUNNING and no stop/reset command is present in that cycle.
  - At TICK_DIV-1 it wraps to 0, and tick_en is registered high for the next single cycle.
  - It holds its value in PAUSED, so a partial second is preserved across pause/resume.
  - It is forced to 0 on a reset command and whenever state is IDLE.
- After entering RUNNING from IDLE, the first tick_en occurs exactly TICK_DIV cycles later, then every TICK_DIV cycles.
- A stop or reset command in the same cycle the prescaler would wrap: the wrap is suppressed and tick_en stays 0.
- tick_en and clr are never high in the same cycle.
- running and paused are registered decodes of the next state; they change in the same cycle as state.

Optional Feature:
STOPWATCH_DEBOUNCE_EN
- Defined:
  - Each synchronised button feeds a counter-based filter. The filtered level changes only after the raw synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
  - Edge detection operates on the filtered level.
  - Button-to-state latency becomes DEBOUNCE_CYCLES+2 cycles.
- Undefined: no filter logic; edge detection uses the synchroniser output directly, and DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset and start, TICK_DIV=10:
  - After rst_n release, outputs are all 0 and state=00.
  - Pulse btn_start for 1 cycle: state=01 two edges later.
  - tick_en pulses at exactly 10, 20 and 30 cycles after entry, each 1 cycle wide.
- Pause preserves phase: stop 4 cycles after a tick, then resume via start.
  - state=10, no tick_en while paused.
  - First tick_en arrives 6 cycles after re-entering RUNNING.
- Reset from RUNNING and from PAUSED:
  - clr is high for exactly 1 cycle and state=00.
  - Prescaler restarts, so the next start gives its first tick after 10 cycles.
- Simultaneous commands:
  - btn_start, btn_stop and btn_reset rising in the same cycle while RUNNING → IDLE with clr.
  - stop arriving in the wrap cycle → PAUSED with no tick_en.
- Held button: btn_start high for 50 cycles from IDLE gives a single transition. Holding btn_stop while PAUSED has no effect.
- With STOPWATCH_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
  - 5-cycle btn_start glitch → no state change.
  - 12-cycle press → RUNNING exactly 10 cycles after the press began.

Source files
------------

// File: rtl/stopwatch_control.sv
// Stopwatch control: button synchronisers, IDLE/RUNNING/PAUSED FSM, 1 s tick prescaler and clear pulse.
// Optional button debounce filter enabled with `define STOPWATCH_DEBOUNCE_EN.
module stopwatch_control #(
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_reset,
  output logic       tick_en,
  output logic       clr,
  output logic       running,
  output logic       paused,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("stopwatch_control: TICK_DIV and DEBOUNCE_CYCLES must both be >= 2");
  end

  // Button bit order: [0] start, [1] stop, [2] reset.
  logic [2:0]    w_btn;
  logic [2:0]    r_sync_p0;
  logic [2:0]    r_sync_p1;
  logic [2:0]    w_lvl;
  logic [2:0]    r_lvl_p2;
  logic [2:0]    w_rise;
  logic          w_cmd_start;
  logic          w_cmd_stop;
  logic          w_cmd_reset;
  state_t        r_state;
  logic          r_clr;
  logic          r_running;
  logic          r_paused;
  logic          r_tick;
  logic [PW-1:0] r_presc;

  assign w_btn = {btn_reset, btn_stop, btn_start};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_btn;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);

  logic [DBW-1:0] r_db_cnt [3];
  logic [2:0]     r_db_lvl;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      r_db_lvl <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync_p1[i] != r_db_lvl[i]) begin
          if (r_db_cnt[i] == DB_MAX) begin
            r_db_lvl[i] <= r_sync_p1[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_lvl = r_db_lvl;
`else
  assign w_lvl = r_sync_p1;
`endif

  // Stage p2: previous level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lvl_p2 <= '0;
    else        r_lvl_p2 <= w_lvl;
  end

  assign w_rise      = w_lvl & ~r_lvl_p2;
  assign w_cmd_reset = w_rise[2];
  assign w_cmd_stop  = w_rise[1] & ~w_rise[2];
  assign w_cmd_start = w_rise[0] & ~w_rise[1] & ~w_rise[2];

  // running/paused track the next state so they switch together with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_reset) begin
            r_clr <= 1'b1;
          end else if (w_cmd_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_cmd_reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_clr     <= 1'b1;
          end else if (w_cmd_stop) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
            r_paused  <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_cmd_reset) begin
            r_state  <= S_IDLE;
            r_paused <= 1'b0;
            r_clr    <= 1'b1;
          end else if (w_cmd_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_paused  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_paused  <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler holds in PAUSED; a stop or reset in the wrap cycle suppresses the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_cmd_reset || r_state == S_IDLE) begin
        r_presc <= '0;
      end else if (r_state == S_RUN && !w_cmd_stop) begin
        if (r_presc == PRESC_MAX) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign tick_en = r_tick;
  assign clr     = r_clr;
  assign running = r_running;
  assign paused  = r_paused;
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with TICK_DIV=10 (and DEBOUNCE_CYCLES=8 when
// STOPWATCH_DEBOUNCE_EN is defined); expected timings are hand-derived per scenario.
module tb_stopwatch_control;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 8;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT  = DEB + 2;
  localparam int HOLD = 12;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 1;
`endif

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_STOP  = 3'b010;
  localparam logic [2:0] B_RESET = 3'b100;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic       tick_en;
  logic       clr;
  logic       running;
  logic       paused;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int entry = 0;
  int last_tick = 0;
  int t_start = 0;

  stopwatch_control #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn[0]),
    .btn_stop  (btn[1]),
    .btn_reset (btn[2]),
    .tick_en   (tick_en),
    .clr       (clr),
    .running   (running),
    .paused    (paused),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  // Presses the masked buttons for 'hold' cycles and checks the transition timing.
  task automatic press(input logic [2:0] mask, input int hold, input logic [1:0] st_old,
                       input logic [1:0] st_new, input logic exp_clr, input string tag);
    int n;
    n = (hold > LAT + 2) ? hold : LAT + 2;
    btn = btn | mask;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == hold) btn = btn & ~mask;
      if (i == LAT) check_val({tag, "_before"}, int'(state), int'(st_old));
      if (i == LAT + 1) begin
        check_val({tag, "_state"}, int'(state), int'(st_new));
        check_val({tag, "_running"}, int'(running), int'(st_new == ST_RUN));
        check_val({tag, "_paused"}, int'(paused), int'(st_new == ST_PAUSE));
        check_val({tag, "_clr"}, int'(clr), int'(exp_clr));
        check_val({tag, "_tick"}, int'(tick_en), 0);
        entry = cyc;
      end
      if (i == LAT + 2) check_val({tag, "_clr_after"}, int'(clr), 0);
    end
  endtask

  task automatic wait_tick(input int ref_c, input int exp, input string tag);
    while (!(tick_en && cyc > ref_c) && (cyc - ref_c) < 100) step();
    check_val(tag, cyc - ref_c, exp);
    last_tick = cyc;
  endtask

  task automatic quiet(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (tick_en) seen++;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    btn   = 3'b000;
    rst_n = 1'b0;
    repeat (3) step();
    check_val("rst_state", int'(state), 0);
    check_val("rst_tick", int'(tick_en), 0);
    check_val("rst_clr", int'(clr), 0);
    check_val("rst_running", int'(running), 0);
    check_val("rst_paused", int'(paused), 0);
    rst_n = 1'b1;
    step();
    check_val("post_rst_state", int'(state), 0);
    check_val("post_rst_tick", int'(tick_en), 0);
    check_val("post_rst_clr", int'(clr), 0);
    repeat (3) step();

    // Start and free-running ticks
    press(B_START, HOLD, ST_IDLE, ST_RUN, 1'b0, "start");
    wait_tick(entry, 10, "tick1");
    wait_tick(last_tick, 10, "tick2");
    wait_tick(last_tick, 10, "tick3");

    // Stop with prescaler at 4, then resume: 6 cycles to the next tick
    step_to(last_tick + 14 - LAT);
    press(B_STOP, HOLD, ST_RUN, ST_PAUSE, 1'b0, "stop");
    quiet(20, "paused_no_tick");
    check_val("paused_hold_state", int'(state), int'(ST_PAUSE));
    press(B_START, HOLD, ST_PAUSE, ST_RUN, 1'b0, "resume");
    wait_tick(entry, 6, "resume_tick");
    wait_tick(last_tick, 10, "resume_tick2");

    // Reset from RUNNING, prescaler restarts
    press(B_RESET, HOLD, ST_RUN, ST_IDLE, 1'b1, "rst_run");
    quiet(15, "idle_no_tick");
    press(B_START, HOLD, ST_IDLE, ST_RUN, 1'b0, "restart");
    wait_tick(entry, 10, "restart_tick");

    // Reset from PAUSED
    press(B_STOP, HOLD, ST_RUN, ST_PAUSE, 1'b0, "stop2");
    repeat (5) step();
    press(B_RESET, HOLD, ST_PAUSE, ST_IDLE, 1'b1, "rst_pause");
    repeat (20) step();
    press(B_START, HOLD, ST_IDLE, ST_RUN, 1'b0, "restart2");
    wait_tick(entry, 10, "restart2_tick");

    // All three buttons together while RUNNING: reset wins
    repeat (3) step();
    press(B_START | B_STOP | B_RESET, HOLD, ST_RUN, ST_IDLE, 1'b1, "simul");
    repeat (20) step();

    // Stop lands in the wrap cycle: tick suppressed, prescaler held at 9
    press(B_START, HOLD, ST_IDLE, ST_RUN, 1'b0, "start_w");
    step_to(entry + 19 - LAT);
    press(B_STOP, HOLD, ST_RUN, ST_PAUSE, 1'b0, "wrap_stop");
    quiet(15, "wrap_no_tick");
    press(B_START, HOLD, ST_PAUSE, ST_RUN, 1'b0, "wrap_resume");
    wait_tick(entry, 1, "wrap_resume_tick");
    wait_tick(last_tick, 10, "wrap_resume_tick2");

    // Held start gives one command; held stop in PAUSED does nothing
    press(B_RESET, HOLD, ST_RUN, ST_IDLE, 1'b1, "rst_h");
    repeat (20) step();
    btn = btn | B_START;
    t_start = cyc;
    repeat (LAT) step();
    check_val("held_start_before", int'(state), int'(ST_IDLE));
    step();
    check_val("held_start_run", int'(state), int'(ST_RUN));
    press(B_STOP, HOLD, ST_RUN, ST_PAUSE, 1'b0, "stop_held_start");
    step_to(t_start + 50);
    check_val("held_start_single", int'(state), int'(ST_PAUSE));
    btn = btn & ~B_START;
    repeat (20) step();
    check_val("held_start_released", int'(state), int'(ST_PAUSE));
    btn = btn | B_STOP;
    repeat (30) step();
    check_val("held_stop", int'(state), int'(ST_PAUSE));
    btn = btn & ~B_STOP;
    repeat (20) step();
    check_val("held_stop_released", int'(state), int'(ST_PAUSE));

`ifdef STOPWATCH_DEBOUNCE_EN
    // Short glitch is filtered; a 12-cycle press lands 10 cycles after it began
    press(B_RESET, HOLD, ST_PAUSE, ST_IDLE, 1'b1, "rst_db");
    repeat (20) step();
    btn = btn | B_START;
    repeat (5) step();
    btn = btn & ~B_START;
    repeat (25) step();
    check_val("glitch_state", int'(state), int'(ST_IDLE));
    press(B_START, 12, ST_IDLE, ST_RUN, 1'b0, "db_press");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
